seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a power of two, 4..64.
REQ-002 clk  input  1  rising-edge clock, sole clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset; SHALL be sampled only on posedge clk.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B; shift amount = b[$clog2(WIDTH)-1:0].
REQ-008 sel  input  3  opcode: 000 NOT a, 001 AND, 010 ADD, 011 SUB (a-b), 100 SHL a by b, 101 MUL, 110 SRA a by b, 111 PASS a.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 o  output  WIDTH  registered result.
REQ-012 nzp  output  3  registered condition codes {N,Z,P}, one-hot.

Function
REQ-013 Accept SHALL occur on a posedge where in_valid && in_ready; a, b and sel SHALL be captured only then.
REQ-014 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready); an output may be consumed and a new operation accepted on the same edge.
REQ-015 State machine: IDLE, MUL. IDLE->MUL on accepting sel=101; MUL->IDLE on the edge that loads the product; all other ops stay IDLE.
REQ-016 Ops 000-100, 110, 111 SHALL have latency 1: the result loads into o and out_valid rises on the accept edge.
REQ-017 MUL SHALL be iterative shift-add, one partial product per cycle, with a counter running WIDTH cycles; o and out_valid SHALL load exactly WIDTH edges after the accept edge.
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; ADD, SUB and MUL SHALL return the low WIDTH bits, with no carry or overflow output.
REQ-019 SHL SHALL zero-fill; SRA SHALL replicate a[WIDTH-1]; a shift amount of 0 SHALL return a.
REQ-020 nzp SHALL update only when o loads: 100 if o[WIDTH-1]=1, 010 if o==0, otherwise 001.
REQ-021 out_valid SHALL clear on an edge with out_valid && out_ready unless a new result loads on that edge; o and nzp SHALL hold while out_valid && !out_ready.
REQ-022 While in MUL, in_ready SHALL be 0 and inputs SHALL be ignored; out_ready SHALL only affect the previous result.

Reset
REQ-023 On rst: state=IDLE, MUL counter=0, out_valid=0, o=0, nzp=010; an in-flight MUL SHALL be discarded.
REQ-024 rst SHALL take priority over accept and consume on the same edge; in_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-025 Macro SEQ_ALU_MUL_EN: when defined, sel=101 behaves per REQ-015/017.
REQ-026 When SEQ_ALU_MUL_EN is undefined, the MUL state and datapath SHALL be absent; sel=101 SHALL complete with latency 1, o=0 and nzp=010.

Verification
REQ-027 WIDTH=16: rst; NOT a=0 -> o=FFFF, nzp=100, 1 cycle after accept; NOT a=100 -> o=FF9B.
REQ-028 AND a=F0F0, b=FF00 -> o=F000; ADD a=3, b=2 -> o=0005, nzp=001; ADD a=3, b=FFFF -> o=0002; SUB a=2, b=2 -> o=0000, nzp=010.
REQ-029 SHL a=0001, b=000F -> o=8000; SRA a=8000, b=0004 -> o=F800, nzp=100; SRA with b=0010 (amount 0) -> o=a.
REQ-030 MUL_EN defined, MUL a=0007, b=0006: in_ready low for 16 cycles; out_valid high 16 edges after accept, o=002A; MUL a=FFFF, b=FFFF -> o=0001.
REQ-031 Back-pressure: hold out_ready=0 after an ADD; in_ready stays 0 and o/nzp hold; then raise out_ready with in_valid=1 -> consume and accept on the same edge, new result loads on the next edge.
REQ-032 Assert rst 5 cycles into a MUL -> o=0000, nzp=010, out_valid=0 and no late result; MUL_EN undefined: sel=101 -> o=0000 after 1 cycle.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu : sequential ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (NOT, AND, ADD, SUB, SHL, SRA, PASS) load the result
// register on the accept edge. MUL (sel=101) is an iterative shift-add
// multiplier that takes WIDTH extra edges. It is built only when the macro
// SEQ_ALU_MUL_EN is defined. Without the macro, sel=101 completes in one
// cycle with o=0 and nzp=010.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operation presented on a/b/sel
//   in_ready   operation is accepted this cycle when in_valid is also high
//   a, b       operands; b[$clog2(WIDTH)-1:0] is the shift amount
//   sel        opcode
//   out_valid  o/nzp hold a result that has not been consumed
//   out_ready  consumer takes the result this cycle
//   o          registered result
//   nzp        registered one-hot condition codes {N,Z,P}
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [2:0]       nzp
);

    localparam int SW = $clog2(WIDTH);

    // Condition codes for a value that is about to load into o.
    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        logic [2:0] r;
        if (v[WIDTH-1]) begin
            r = 3'b100;
        end else if (v == '0) begin
            r = 3'b010;
        end else begin
            r = 3'b001;
        end
        return r;
    endfunction

    logic [WIDTH-1:0] o_q, o_d;
    logic [2:0]       nzp_q, nzp_d;
    logic             out_valid_q, out_valid_d;

    logic             idle_s;
    logic             accept_s;
    logic             start_mul_s;
    logic             mul_done_s;
    logic [WIDTH-1:0] mul_res_s;
    logic             load_s;
    logic [WIDTH-1:0] load_val_s;
    logic [WIDTH-1:0] alu_s;
    logic [SW-1:0]    shamt_s;

    assign shamt_s  = b[SW-1:0];
    assign in_ready = idle_s && (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;

    // Single-cycle result for every opcode; sel=101 yields 0 here and is only
    // used when the multiplier is not built.
    always_comb begin
        alu_s = '0;
        case (sel)
            3'b000:  alu_s = ~a;
            3'b001:  alu_s = a & b;
            3'b010:  alu_s = a + b;
            3'b011:  alu_s = a - b;
            3'b100:  alu_s = a << shamt_s;
            3'b101:  alu_s = '0;
            3'b110:  alu_s = $unsigned($signed(a) >>> shamt_s);
            3'b111:  alu_s = a;
            default: alu_s = a;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step_s;

    assign idle_s      = (state_q == ST_IDLE);
    assign start_mul_s = accept_s && (sel == 3'b101);
    // One partial product per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set. Bits above WIDTH are dropped (mod 2^WIDTH).
    assign acc_step_s  = acc_q + (mplr_q[0] ? mcand_q : '0);
    assign mul_res_s   = acc_step_s;

    // Multiplier FSM and datapath next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        acc_d      = acc_q;
        mul_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_mul_s) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                    mcand_d = a;
                    mplr_d  = b;
                    acc_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_d   = acc_step_s;
                mcand_d = {mcand_q[WIDTH-2:0], 1'b0};
                mplr_d  = {1'b0, mplr_q[WIDTH-1:1]};
                // The last of WIDTH steps loads the product directly.
                if (cnt_q == SW'(WIDTH - 1)) begin
                    mul_done_s = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier state registers; reset discards any in-flight product.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
        end
    end
`else
    assign idle_s      = 1'b1;
    assign start_mul_s = 1'b0;
    assign mul_done_s  = 1'b0;
    assign mul_res_s   = '0;
`endif

    assign load_s = (accept_s && !start_mul_s) || mul_done_s;

    // Pick the value that loads into the result register.
    always_comb begin
        if (mul_done_s) begin
            load_val_s = mul_res_s;
        end else begin
            load_val_s = alu_s;
        end
    end

    // Result register next state: a new load wins over a consume.
    always_comb begin
        o_d         = o_q;
        nzp_d       = nzp_q;
        out_valid_d = out_valid_q;
        if (load_s) begin
            o_d         = load_val_s;
            nzp_d       = nzp_of(load_val_s);
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q         <= '0;
            nzp_q       <= 3'b010;
            out_valid_q <= 1'b0;
        end else begin
            o_q         <= o_d;
            nzp_q       <= nzp_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign o         = o_q;
    assign nzp       = nzp_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] o;
    logic [2:0]  nzp;

    int vecs = 0;
    int errs = 0;
    bit chk_en = 1'b0;

`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .nzp(nzp)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_valid = 1'b0;
    logic [15:0] m_o = 16'h0000;
    logic [2:0]  m_nzp = 3'b010;
    int          m_busy = 0;
    logic [15:0] m_mul = 16'h0000;

    function automatic logic [15:0] ref_op(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y);
        int sh;
        longint p;
        logic [15:0] r;
        sh = int'(y) % 16;
        p  = longint'(x) * longint'(y);
        case (s)
            3'd0: r = ~x;
            3'd1: r = x & y;
            3'd2: r = 16'((int'(x) + int'(y)) % 65536);
            3'd3: r = 16'((int'(x) - int'(y) + 65536) % 65536);
            3'd4: r = 16'((longint'(x) * (longint'(1) << sh)) % 65536);
            3'd5: r = MUL_EN ? p[15:0] : 16'h0000;
            3'd6: r = x[15] ? ~((~x) >> sh) : (x >> sh);
            default: r = x;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [15:0] v);
        if (v == 16'h0000) return 3'b010;
        if (v >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    function automatic logic exp_ready();
        return (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    // Model advances on each rising edge from the inputs present at that edge.
    always @(posedge clk) begin
        logic rdy;
        if (rst) begin
            m_valid = 1'b0; m_o = 16'h0000; m_nzp = 3'b010; m_busy = 0;
        end else begin
            rdy = exp_ready();
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    m_o = m_mul; m_nzp = ref_nzp(m_mul); m_valid = 1'b1;
                end
            end else if (in_valid && rdy) begin
                if (MUL_EN && sel == 3'd5) begin
                    m_busy = 16; m_mul = ref_op(sel, a, b);
                end else begin
                    m_o = ref_op(sel, a, b); m_nzp = ref_nzp(m_o); m_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("o", 32'(o), 32'(m_o));
            chk("nzp", 32'(nzp), 32'(m_nzp));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input string nm, input logic [2:0] s, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] eo,
                          input logic [2:0] en, input int elat);
        int n;
        int lat;
        @(posedge clk); #1;
        a = av; b = bv; sel = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #2; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(elat));
        chk({nm, "_o"}, 32'(o), 32'(eo));
        chk({nm, "_nzp"}, 32'(nzp), 32'(en));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o", 32'(o), 32'h0000);
        chk("rst_nzp", 32'(nzp), 32'(3'b010));
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        run_op("not0",   3'd0, 16'h0000, 16'h0000, 16'hFFFF, 3'b100, 1);
        run_op("not100", 3'd0, 16'd100,  16'h0000, 16'hFF9B, 3'b100, 1);
        run_op("and",    3'd1, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1);
        run_op("add",    3'd2, 16'h0003, 16'h0002, 16'h0005, 3'b001, 1);
        run_op("addwrap",3'd2, 16'h0003, 16'hFFFF, 16'h0002, 3'b001, 1);
        run_op("sub",    3'd3, 16'h0002, 16'h0002, 16'h0000, 3'b010, 1);
        run_op("shl",    3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b100, 1);
        run_op("sra",    3'd6, 16'h8000, 16'h0004, 16'hF800, 3'b100, 1);
        run_op("sra0",   3'd6, 16'h1234, 16'h0010, 16'h1234, 3'b001, 1);
        run_op("pass",   3'd7, 16'hABCD, 16'h0001, 16'hABCD, 3'b100, 1);
`ifdef SEQ_ALU_MUL_EN
        run_op("mul76",  3'd5, 16'h0007, 16'h0006, 16'h002A, 3'b001, 16);
        run_op("mulff",  3'd5, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b001, 16);
        // Reset part-way through a multiply discards it.
        @(posedge clk); #1;
        a = 16'h0007; b = 16'h0006; sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mulrst_o", 32'(o), 32'h0000);
        chk("mulrst_nzp", 32'(nzp), 32'(3'b010));
        chk("mulrst_valid", 32'(out_valid), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("mulrst_nolate", 32'(out_valid), 32'd0);
`else
        run_op("mul_off", 3'd5, 16'h0007, 16'h0006, 16'h0000, 3'b010, 1);
`endif

        // Back-pressure: result held, then consume and accept on one edge.
        @(posedge clk); #1;
        a = 16'h0010; b = 16'h0020; sel = 3'd2; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; sel = 3'd2; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_rdy", 32'(in_ready), 32'd0);
        chk("bp_o", 32'(o), 32'h0030);
        chk("bp_nzp", 32'(nzp), 32'(3'b001));
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_up", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_o", 32'(o), 32'h3333);
        chk("bp_new_valid", 32'(out_valid), 32'd1);

        // Randomised traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 199) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'h8000;
                default: a = 16'($urandom);
            endcase
            b = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
